// File: rtl/multi_digit_led_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_digit_led_scanner_pkg: segment table, display phase, width helper   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package multi_digit_led_scanner_pkg;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_SHOW = 1'b1
  } phase_e;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_digit_led_scanner_seg7_hex_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_hex_decode: combinational hex nibble to active-low 7-segment        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg7_hex_decode
  import multi_digit_led_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/multi_digit_led_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_digit_led_scanner: N-digit multiplexed 7-seg driver, frame-synced  |
// | data updates, dead time, blanking and decimal points. Revision: 1.0      |
// +--------------------------------------------------------------------------+
module multi_digit_led_scanner
  import multi_digit_led_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 16,
  parameter int DEAD_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    load,
  output logic                    update_pending,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int CNT_W  = width_of(PRESCALE);
  localparam int SLOT_W = width_of(NUM_DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [SLOT_W-1:0]       slot, slot_nxt;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] sh_data, disp_data;
  logic [NUM_DIGITS-1:0]   sh_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   sh_blank, disp_blank;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    in_dead;
  phase_e                  phase;
  logic [6:0]              dec_seg;

  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  // Slot sequencer: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      slot <= '0;
    end else begin
      cnt  <= cnt_nxt;
      slot <= slot_nxt;
    end
  end

  // Slot sequencer: next state; the last cycle of the last slot is the frame boundary
  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    slot_nxt = slot;
    boundary = 1'b0;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      if (slot == SLOT_LAST) begin
        slot_nxt = '0;
        boundary = 1'b1;
      end else begin
        slot_nxt = slot + 1'b1;
      end
    end
  end

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt < CNT_W'(DEAD_CYCLES));
    end
  endgenerate

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == SLOT_W'(i)) begin
        cur_nib   = disp_data[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = disp_blank[i];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    phase   = (in_dead || cur_blank) ? PH_DEAD : PH_SHOW;
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (phase == PH_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_nxt[i] = (slot != SLOT_W'(i));
      end
      seg_nxt = dec_seg;
      dp_nxt  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= boundary;
    end
  end

  // A load on the boundary edge bypasses the shadow so it is never a frame late
  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_data        <= '0;
      sh_dp          <= '0;
      sh_blank       <= '0;
      disp_data      <= '0;
      disp_dp        <= '0;
      disp_blank     <= '0;
      update_pending <= 1'b0;
    end else begin
      if (load) begin
        sh_data  <= digit_data;
        sh_dp    <= dp_in;
        sh_blank <= blank_mask;
      end
      if (boundary) begin
        update_pending <= 1'b0;
        if (load) begin
          disp_data  <= digit_data;
          disp_dp    <= dp_in;
          disp_blank <= blank_mask;
        end else if (update_pending) begin
          disp_data  <= sh_data;
          disp_dp    <= sh_dp;
          disp_blank <= sh_blank;
        end
      end else if (load) begin
        update_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_led_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_multi_digit_led_scanner: frame scoreboard for DEAD_CYCLES=1 and =0    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multi_digit_led_scanner;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int FRAME = ND * PS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digit_data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;

  logic        pend_a, tick_a, dp_a, pend_b, tick_b, dp_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  always #5 clk = ~clk;

  multi_digit_led_scanner #(.NUM_DIGITS(ND), .PRESCALE(PS), .DEAD_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .digit_data(digit_data), .dp_in(dp_in),
    .blank_mask(blank_mask), .load(load), .update_pending(pend_a),
    .frame_tick(tick_a), .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  multi_digit_led_scanner #(.NUM_DIGITS(ND), .PRESCALE(PS), .DEAD_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .digit_data(digit_data), .dp_in(dp_in),
    .blank_mask(blank_mask), .load(load), .update_pending(pend_b),
    .frame_tick(tick_b), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dpm;
    logic [3:0]  blk;
  } frame_t;

  frame_t q_a[$];
  frame_t q_b[$];
  int checks = 0;
  int fails = 0;
  int pushed = 0;
  int done_a = 0;
  int done_b = 0;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: seg_ref = 7'b0000001;  4'h1: seg_ref = 7'b1001111;
      4'h2: seg_ref = 7'b0010010;  4'h3: seg_ref = 7'b0000110;
      4'h4: seg_ref = 7'b1001100;  4'h5: seg_ref = 7'b0100100;
      4'h6: seg_ref = 7'b0100000;  4'h7: seg_ref = 7'b0001111;
      4'h8: seg_ref = 7'b0000000;  4'h9: seg_ref = 7'b0000100;
      4'hA: seg_ref = 7'b0001000;  4'hB: seg_ref = 7'b1100000;
      4'hC: seg_ref = 7'b0110001;  4'hD: seg_ref = 7'b1000010;
      4'hE: seg_ref = 7'b0110000;  default: seg_ref = 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an_a"}, 32'(an_a), 32'hF);
    chk({tag, "_seg_a"}, 32'(seg_a), 32'h7F);
    chk({tag, "_dp_a"}, 32'(dp_a), 32'h1);
    chk({tag, "_pend_a"}, 32'(pend_a), 32'h0);
    chk({tag, "_tick_a"}, 32'(tick_a), 32'h0);
    chk({tag, "_an_b"}, 32'(an_b), 32'hF);
    chk({tag, "_seg_b"}, 32'(seg_b), 32'h7F);
    chk({tag, "_dp_b"}, 32'(dp_b), 32'h1);
    chk({tag, "_pend_b"}, 32'(pend_b), 32'h0);
    chk({tag, "_tick_b"}, 32'(tick_b), 32'h0);
  endtask

  task automatic chk_pend(input string name, input logic exp);
    chk({name, "_a"}, 32'(pend_a), 32'(exp));
    chk({name, "_b"}, 32'(pend_b), 32'(exp));
  endtask

  task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    frame_t f;
    f.digits = d;
    f.dpm    = p;
    f.blk    = b;
    q_a.push_back(f);
    q_b.push_back(f);
    pushed++;
  endtask

  task automatic wait_tick(input string why, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tick_a !== 1'b1 && n < 200);
    if (tick_a !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL %s: no frame_tick within 200 cycles, got 0, expected 1", why);
    end
  endtask

  function automatic bit take(input int id, output frame_t f);
    take = 1'b0;
    f = '0;
    if (id == 0) begin
      if (q_a.size() > 0) begin f = q_a.pop_front(); take = 1'b1; end
    end else if (q_b.size() > 0) begin
      f = q_b.pop_front();
      take = 1'b1;
    end
  endfunction

  task automatic retire(input int id, input bit bad, input string msg);
    checks++;
    if (id == 0) done_a++; else done_b++;
    if (bad) begin
      fails++;
      $display("FAIL frame_dead%0d: %s", (id == 0) ? 1 : 0, msg);
    end
  endtask

  // One monitor per DUT: a frame's 16 output cycles start right after a
  // frame_tick (or right after reset release) and end on the next tick cycle.
  task automatic monitor(input int id);
    int dead = (id == 0) ? 1 : 0;
    frame_t cur;
    bit active = 0, start_next = 0, prev_rst = 1, bad = 0, dk;
    int k = 0, cyc = 0, last_tick = -1, slot, cnt;
    logic [3:0] an_s, e_an;
    logic [6:0] seg_s, e_seg;
    logic dp_s, tick_s, e_dp;
    string msg = "";
    forever begin
      @(negedge clk);
      cyc++;
      an_s   = (id == 0) ? an_a : an_b;
      seg_s  = (id == 0) ? seg_a : seg_b;
      dp_s   = (id == 0) ? dp_a : dp_b;
      tick_s = (id == 0) ? tick_a : tick_b;
      if (reset !== 1'b1) begin
        if (active) retire(id, bad, msg);
        active = 0; start_next = 0; prev_rst = 0; last_tick = -1;
        if (id == 0) q_a.delete(); else q_b.delete();
        continue;
      end
      if (start_next) begin
        start_next = 0;
        if (take(id, cur)) begin active = 1; k = 0; bad = 0; end
      end
      if (!prev_rst) start_next = 1;
      prev_rst = 1;
      if (active) begin
        slot  = k / PS;
        cnt   = k % PS;
        dk    = (cnt < dead) || cur.blk[slot];
        e_an  = dk ? 4'hF : ~(4'b0001 << slot);
        e_seg = dk ? 7'h7F : seg_ref(cur.digits[slot*4 +: 4]);
        e_dp  = dk ? 1'b1 : ~cur.dpm[slot];
        if (!bad && (an_s !== e_an || seg_s !== e_seg || dp_s !== e_dp)) begin
          bad = 1;
          msg = $sformatf("digits=%h cycle %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                          cur.digits, k, an_s, seg_s, dp_s, e_an, e_seg, e_dp);
        end
        k++;
        if (k == FRAME) begin
          retire(id, bad, msg);
          active = 0;
        end
      end
      if (tick_s === 1'b1) begin
        if (last_tick >= 0)
          chk($sformatf("tick_period_dead%0d", (id == 0) ? 1 : 0), 32'(cyc - last_tick), 32'(FRAME));
        last_tick = cyc;
        if (active) begin
          retire(id, 1'b1, $sformatf("tick at cycle %0d of frame, expected at cycle %0d", k, FRAME));
          active = 0;
        end
        if (take(id, cur)) begin active = 1; k = 0; bad = 0; end
      end
    end
  endtask

  initial begin
    int n;
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset held three cycles
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("t1_reset");

    // Cleared display shows zeros; 4321 becomes visible one frame later
    push_frame(16'h0000, 4'h0, 4'h0);
    reset = 1'b1;
    load = 1'b1; digit_data = 16'h4321; dp_in = 4'h0; blank_mask = 4'h0;
    @(posedge clk); #1;
    load = 1'b0;
    chk_pend("t2_pending_set", 1'b1);
    wait_tick("t2_boundary", n);
    push_frame(16'h4321, 4'h0, 4'h0);
    chk_pend("t2_pending_cleared", 1'b0);

    // Mid-frame load: current frame keeps 4321
    repeat (3) @(posedge clk);
    #1;
    load = 1'b1; digit_data = 16'h8888;
    @(posedge clk); #1;
    load = 1'b0;
    chk_pend("t3_pending_set", 1'b1);
    wait_tick("t3_boundary", n);
    push_frame(16'h8888, 4'h0, 4'h0);
    chk_pend("t3_pending_cleared", 1'b0);

    // Blanked digit 2, decimal point on digit 0
    repeat (6) @(posedge clk);
    #1;
    load = 1'b1; digit_data = 16'h5A6B; dp_in = 4'b0001; blank_mask = 4'b0100;
    @(posedge clk); #1;
    load = 1'b0;
    chk_pend("t4_pending_set", 1'b1);
    wait_tick("t4_boundary", n);
    push_frame(16'h5A6B, 4'b0001, 4'b0100);
    chk_pend("t4_pending_cleared", 1'b0);

    // Load exactly on the boundary cycle
    repeat (FRAME - 1) @(posedge clk);
    #1;
    load = 1'b1; digit_data = 16'hFEDC; dp_in = 4'h0; blank_mask = 4'h0;
    wait_tick("t5_boundary", n);
    load = 1'b0;
    chk("t5_boundary_alignment", 32'(n), 32'd1);
    push_frame(16'hFEDC, 4'h0, 4'h0);
    chk_pend("t5_pending_stays_0", 1'b0);

    // Reset in slot 2 with an update pending
    repeat (2) @(posedge clk);
    #1;
    load = 1'b1; digit_data = 16'h1111;
    @(posedge clk); #1;
    load = 1'b0;
    chk_pend("t6_pending_set", 1'b1);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("t6_reset");
    push_frame(16'h0000, 4'h0, 4'h0);
    reset = 1'b1;
    wait_tick("t6_restart", n);
    chk("t6_restart_alignment", 32'(n), 32'(FRAME));
    push_frame(16'h0000, 4'h0, 4'h0);
    chk_pend("t6_pending_discarded", 1'b0);
    wait_tick("t6_end", n);
    repeat (2) @(negedge clk);

    chk("frames_checked_dead1", 32'(done_a), 32'(pushed));
    chk("frames_checked_dead0", 32'(done_b), 32'(pushed));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
